// File: rtl/lms_iter_sequencer.sv
// LMS adaptation loop sequencer: snapshot handshake, pipeline drain wait, weight write strobe, iteration count.
// Optional early-stop on error magnitude is compiled in with `define LMS_SEQ_EARLY_STOP_EN.
module lms_iter_sequencer #(
  parameter int PIPE_LAT = 6,
  parameter int ITER_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ITER_W-1:0] n_iter,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ld_en,
  output logic              w_sel,
  output logic              upd_en,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              busy,
  output logic              done
`ifdef LMS_SEQ_EARLY_STOP_EN
  ,
  input  logic [17:0]       err_mag,
  input  logic [17:0]       err_thr,
  output logic              conv
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_S = 3'd1,
    PIPE   = 3'd2,
    UPDATE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state;
  logic [7:0]        lat_cnt;
  logic [ITER_W-1:0] n_lat;
  logic              accept;
  logic              last_iter;
  logic              early;

  // s_ready is a registered decode of WAIT_S, so ld_en is only gated by the source.
  assign accept = s_valid & s_ready;
  assign ld_en  = accept;

  assign last_iter = ({1'b0, iter_cnt} + 1'b1) == {1'b0, n_lat};

`ifdef LMS_SEQ_EARLY_STOP_EN
  assign early = err_mag < err_thr;
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      n_lat    <= '0;
      iter_cnt <= '0;
      s_ready  <= 1'b0;
      w_sel    <= 1'b0;
      upd_en   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef LMS_SEQ_EARLY_STOP_EN
      conv     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_lat    <= n_iter;
            iter_cnt <= '0;
            w_sel    <= 1'b0;
`ifdef LMS_SEQ_EARLY_STOP_EN
            conv     <= 1'b0;
`endif
            if (n_iter == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= WAIT_S;
              s_ready <= 1'b1;
              busy    <= 1'b1;
            end
          end
        end
        WAIT_S: begin
          if (accept) begin
            lat_cnt <= 8'(PIPE_LAT - 1);
            s_ready <= 1'b0;
            state   <= PIPE;
          end
        end
        PIPE: begin
          // Counter preloaded with PIPE_LAT-1 so this state spans exactly PIPE_LAT cycles.
          if (lat_cnt == '0) begin
            state  <= UPDATE;
            upd_en <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        UPDATE: begin
          upd_en <= 1'b0;
          w_sel  <= 1'b1;
          if (iter_cnt != '1) iter_cnt <= iter_cnt + 1'b1;
          if (last_iter || early) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
`ifdef LMS_SEQ_EARLY_STOP_EN
            conv  <= early;
`endif
          end else begin
            state   <= WAIT_S;
            s_ready <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          upd_en  <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lms_iter_sequencer.sv
// Scoreboard bench for lms_iter_sequencer: driver predicts ld_en/upd_en/done events, monitor checks them.
module tb_lms_iter_sequencer;
  localparam int P  = 6;
  localparam int IW = 16;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          start = 0;
  logic [IW-1:0] n_iter = '0;
  logic          s_valid = 0;
  logic          s_ready, ld_en, w_sel, upd_en, busy, done;
  logic [IW-1:0] iter_cnt;

  lms_iter_sequencer #(.PIPE_LAT(P), .ITER_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_iter(n_iter),
    .s_valid(s_valid), .s_ready(s_ready), .ld_en(ld_en), .w_sel(w_sel),
    .upd_en(upd_en), .iter_cnt(iter_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int kind; int it; int ws; } evt_t; // kind 0=ld 1=upd 2=done
  evt_t q[$];

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input int k, input int it, input int ws);
    evt_t e;
    e.cyc = c; e.kind = k; e.it = it; e.ws = ws;
    q.push_back(e);
  endtask

  // Monitor: each observed event must match the oldest prediction.
  always @(negedge clk) begin
    if (rst_n) begin
      int kind;
      evt_t e;
      if (ld_en && upd_en) chk("ld_upd_overlap", 1, 0);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missed_event_cycle", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (ld_en || upd_en || done) begin
        kind = ld_en ? 0 : (upd_en ? 1 : 2);
        if (q.size() == 0) chk("unexpected_event_kind", kind, -1);
        else begin
          e = q.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("event_kind", kind, e.kind);
          chk("event_iter_cnt", int'(iter_cnt), e.it);
          chk("event_w_sel", int'(w_sel), e.ws);
        end
      end
    end
  end

  // One run: s_valid is random with pct% probability (forced low for the first
  // `stall` cycles); start/n_iter are randomly re-pulsed mid-run and must be ignored.
  task automatic run(input int n, input int pct, input int stall);
    int s, ready, k, donec, c, sv;
    bit exp_rdy, exp_busy;
    @(posedge clk); #1;
    s = cyc; start = 1; n_iter = IW'(n); s_valid = 0;
    ready = s + 1; k = 1; donec = -1;
    if (n == 0) begin donec = s + 1; push(donec, 2, 0, 0); end
    forever begin
      @(posedge clk); #1;
      c = cyc; start = 0;
      if (donec >= 0 && c > donec) begin s_valid = 0; break; end
      if (c > s + 5000) begin chk("run_timeout", c, s); q.delete(); break; end
      sv = (c - s <= stall) ? 0 : int'($urandom_range(99) < pct);
      s_valid = sv[0];
      if ((donec < 0 || c <= donec) && $urandom_range(9) == 0) begin
        start = 1; n_iter = IW'($urandom);
      end
      exp_rdy  = (k <= n) && (c >= ready);
      exp_busy = (n > 0) && (donec < 0 || c < donec);
      if (exp_rdy && sv != 0) begin
        push(c, 0, k - 1, int'(k > 1));
        push(c + P + 1, 1, k - 1, int'(k > 1));
        if (k == n) begin donec = c + P + 2; push(donec, 2, n, 1); end
        ready = c + P + 2;
        k++;
      end
      @(negedge clk);
      chk("s_ready", int'(s_ready), int'(exp_rdy));
      chk("busy", int'(busy), int'(exp_busy));
      if (c - s <= stall && stall > 0) chk("stall_ld_en", int'(ld_en), 0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"}, int'(s_ready), 0);
    chk({tag, "_ld_en"}, int'(ld_en), 0);
    chk({tag, "_upd_en"}, int'(upd_en), 0);
    chk({tag, "_w_sel"}, int'(w_sel), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_iter_cnt"}, int'(iter_cnt), 0);
  endtask

  initial begin
    int s;
    #3;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    run(3, 100, 0);   // basic: back-to-back snapshots, 8-cycle spacing
    run(0, 100, 0);   // zero count
    run(2, 100, 10);  // stalled source

    // Reset in PIPE of iteration 2 aborts the run immediately.
    @(posedge clk); #1;
    s = cyc; start = 1; n_iter = 3; s_valid = 1;
    push(s + 1, 0, 0, 0); push(s + 1 + P + 1, 1, 0, 0); push(s + 1 + P + 2, 0, 1, 1);
    while (cyc < s + P + 6) begin @(posedge clk); #1; start = 0; end
    rst_n = 0; q.delete();
    #1 chk_all_zero("midrun_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1; s_valid = 0;
    repeat (8) @(posedge clk);
    #1 chk("post_reset_idle_busy", int'(busy), 0);
    run(1, 100, 0);

    for (int i = 0; i < 15; i++)
      run(int'($urandom_range(5)), int'($urandom_range(100, 30)), int'($urandom_range(3)));

    repeat (20) @(posedge clk);
    #1 chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
